count_display_mux: RTL and testbench

- Downstream consumer of the 4-bit free-running counter output.
- Converts the count (0-15) into two decimal digits and drives a 2-digit, time-multiplexed seven-segment display.
- The count is sampled only at frame boundaries, so the display never tears mid-frame.
- Sits between the counter and the board display pins; the refresh divider runs on the system clock.

---
 rtl/count_display_mux.sv | 138 +++++++++++++
 tb/tb_count_display_mux.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/count_display_mux.sv
// count_display_mux
//   Shows a 4-bit count (0-15) as two decimal digits on a two-digit,
//   time-multiplexed seven-segment display. The count is sampled once
//   per frame, so a frame never mixes digits from two different values.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         refresh enable; low freezes all state
//   count_in   value to display, unsigned 0-15
//   seg        segment drive, bit0=a .. bit6=g (registered)
//   an         digit enables, an[0]=units, an[1]=tens (registered)
//   frame_tick one-cycle pulse whenever count_in is sampled (registered)
module count_display_mux #(
  parameter int REFRESH_DIV        = 50000,
  parameter bit ACTIVE_LOW         = 1'b1,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] count_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST     = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [1:0]    AN_OFF   = {2{ACTIVE_LOW}};

  logic [CW-1:0] ref_cnt_q, ref_cnt_d;
  logic          digit_sel_q, digit_sel_d;
  logic [3:0]    held_q, held_d;
  logic          active_q, active_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_tick_q, frame_tick_d;

  logic          slot_edge;
  logic [6:0]    seg_hi;
  logic [1:0]    an_hi;
  logic [3:0]    tens_digit;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] units_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  function automatic logic [3:0] tens_of(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  always_comb begin
    ref_cnt_d    = ref_cnt_q;
    digit_sel_d  = digit_sel_q;
    held_d       = held_q;
    active_d     = active_q;
    seg_d        = seg_q;
    an_d         = an_q;
    frame_tick_d = 1'b0;
    seg_hi       = '0;
    an_hi        = '0;
    tens_digit   = tens_of(held_q);

    // en low wins over a coinciding slot edge: nothing advances at all.
    slot_edge = en && (ref_cnt_q == LAST);

    if (en) begin
      ref_cnt_d = slot_edge ? '0 : ref_cnt_q + CW'(1);
    end

    if (slot_edge) begin
      digit_sel_d = ~digit_sel_q;
      if (digit_sel_q) begin
        // Frame edge: units shown straight from count_in, no extra latency.
        held_d       = count_in;
        active_d     = 1'b1;
        frame_tick_d = 1'b1;
        seg_hi       = seg_code(units_of(count_in));
        an_hi        = 2'b01;
      end else if (active_q) begin
        if (BLANK_LEADING_ZERO && (tens_digit == 4'd0)) begin
          seg_hi = '0;
          an_hi  = '0;
        end else begin
          seg_hi = seg_code(tens_digit);
          an_hi  = 2'b10;
        end
      end
      seg_d = seg_hi ^ SEG_OFF;
      an_d  = an_hi ^ AN_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q    <= '0;
      digit_sel_q  <= 1'b1;
      held_q       <= '0;
      active_q     <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      ref_cnt_q    <= ref_cnt_d;
      digit_sel_q  <= digit_sel_d;
      held_q       <= held_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_count_display_mux.sv
// Bench for count_display_mux: three configurations share clock and
// stimulus; a cycle-count reference model predicts every output.
module tb_count_display_mux;

  localparam int NCFG = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] count_in = '0;

  logic [6:0] seg [NCFG];
  logic [1:0] an  [NCFG];
  logic       tick[NCFG];

  always #5 clk = ~clk;

  count_display_mux #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in),
    .seg(seg[0]), .an(an[0]), .frame_tick(tick[0]));

  count_display_mux #(.REFRESH_DIV(3), .ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in),
    .seg(seg[1]), .an(an[1]), .frame_tick(tick[1]));

  count_display_mux #(.REFRESH_DIV(5), .ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in),
    .seg(seg[2]), .an(an[2]), .frame_tick(tick[2]));

  int cfg_div [NCFG] = '{4, 3, 5};
  int cfg_al  [NCFG] = '{1'b0, 1'b0, 1'b1};
  int cfg_bl  [NCFG] = '{1'b1, 1'b0, 1'b1};

  int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  // Model state: enabled cycles since reset (mod 2*DIV) and sampled value.
  int m_n    [NCFG];
  int m_held [NCFG];
  int e_seg  [NCFG];
  int e_an   [NCFG];
  int e_tick [NCFG];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int invert_if(input int v, input int width, input int al);
    return al ? (~v & ((1 << width) - 1)) : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) begin
      m_n[i]    = 0;
      m_held[i] = 0;
      e_seg[i]  = invert_if(0, 7, cfg_al[i]);
      e_an[i]   = invert_if(0, 2, cfg_al[i]);
      e_tick[i] = 0;
    end
  endtask

  // Predicts the outputs after the coming rising edge for inputs en/cin.
  task automatic model_step(input int en_v, input int cin);
    int s, a;
    for (int i = 0; i < NCFG; i++) begin
      e_tick[i] = 0;
      if (en_v != 0) begin
        m_n[i] = (m_n[i] + 1) % (2 * cfg_div[i]);
        if (m_n[i] == cfg_div[i]) begin
          m_held[i] = cin;
          e_tick[i] = 1;
          s = seg_tab[cin % 10];
          a = 1;
          e_seg[i] = invert_if(s, 7, cfg_al[i]);
          e_an[i]  = invert_if(a, 2, cfg_al[i]);
        end else if (m_n[i] == 0) begin
          if (cfg_bl[i] != 0 && m_held[i] / 10 == 0) begin
            s = 0;
            a = 0;
          end else begin
            s = seg_tab[m_held[i] / 10];
            a = 2;
          end
          e_seg[i] = invert_if(s, 7, cfg_al[i]);
          e_an[i]  = invert_if(a, 2, cfg_al[i]);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("%s_seg%0d", tag, i), int'(seg[i]), e_seg[i]);
      check($sformatf("%s_an%0d", tag, i), int'(an[i]), e_an[i]);
      check($sformatf("%s_tick%0d", tag, i), int'(tick[i]), e_tick[i]);
    end
  endtask

  task automatic drive(input logic en_v, input logic [3:0] cin);
    en       = en_v;
    count_in = cin;
    model_step(int'(en_v), int'(cin));
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("in_rst");
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Directed phases: first frame / blanked tens, 13, 15, tear-free, en hold.
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, 4'd7);
      @(negedge clk); check_all("d7");
    end
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, 4'd13);
      @(negedge clk); check_all("d13");
    end
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, (c % 10 == 3) ? 4'd12 : 4'd9);
      @(negedge clk); check_all("tear");
    end
    for (int c = 0; c < 30; c++) begin
      drive((c >= 6 && c < 16) ? 1'b0 : 1'b1, 4'd15);
      @(negedge clk); check_all("hold");
    end
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, 4'd5);
      @(negedge clk); check_all("d5");
    end
    async_reset();

    // Randomised run with occasional mid-scan asynchronous resets.
    begin
      logic [3:0] cin_r;
      logic       en_r;
      cin_r = 4'd0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(3, 0) == 0) cin_r = 4'($urandom_range(15, 0));
        en_r = ($urandom_range(7, 0) != 0);
        drive(en_r, cin_r);
        @(negedge clk);
        check_all("rand");
        if ($urandom_range(299, 0) == 0) async_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
